// File: rtl/ysyx22041405_pkg.sv
// Shared IFU definitions: fetch FSM state encoding and architectural constants.
package ysyx22041405_pkg;

   localparam int unsigned XLEN         = 32;
   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_OUT  = 2'd3
   } ifu_state_e;

endpackage

// File: rtl/ysyx22041405_ifu.sv
// Instruction fetch unit: one outstanding memory read at a time, with redirect
// handling that discards in-flight or held instructions from the wrong path.
module ysyx22041405_ifu
   import ysyx22041405_pkg::*;
#(
   parameter int unsigned     WIDTH    = XLEN,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IFU_RESET_PC)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             req_valid,
   output logic [WIDTH-1:0] req_addr,
   input  logic             req_ready,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
   output logic             inst_valid,
   output logic [WIDTH-1:0] inst,
   output logic [WIDTH-1:0] pc,
   input  logic             inst_ready,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc
);

   ifu_state_e       state_q, state_d;
   logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [WIDTH-1:0] inst_q, inst_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             drop_q, drop_d;
   logic             req_valid_q, req_valid_d;
   logic             inst_valid_q, inst_valid_d;
   logic             req_fire;
   logic             out_fire;

   assign req_fire = req_valid_q && req_ready;
   assign out_fire = inst_valid_q && inst_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ:  if (req_fire) state_d = S_WAIT;
         // A dropped or redirected response is thrown away and fetching restarts.
         S_WAIT: if (resp_valid) state_d = (drop_q || redirect_valid) ? S_REQ : S_OUT;
         S_OUT:  if (redirect_valid || out_fire) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      inst_d       = inst_q;
      pc_d         = pc_q;
      drop_d       = drop_q;
      req_valid_d  = (state_d == S_REQ);
      inst_valid_d = (state_d == S_OUT);
      case (state_q)
         S_REQ: if (req_fire && redirect_valid) drop_d = 1'b1;
         S_WAIT: begin
            if (resp_valid) begin
               drop_d = 1'b0;
               if (!drop_q && !redirect_valid) begin
                  inst_d = resp_data;
                  pc_d   = fetch_pc_q;
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
            end
         end
         S_OUT: if (out_fire) fetch_pc_d = pc_q + WIDTH'(4);
         default: ;
      endcase
      // Redirect wins over sequential advance in every state.
      if (redirect_valid) fetch_pc_d = {redirect_pc[WIDTH-1:2], 2'b00};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         inst_q       <= WIDTH'(NOP_INST);
         pc_q         <= RESET_PC;
         drop_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         inst_q       <= inst_d;
         pc_q         <= pc_d;
         drop_q       <= drop_d;
         req_valid_q  <= req_valid_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign req_valid  = req_valid_q;
   assign req_addr   = fetch_pc_q;
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;
   assign pc         = pc_q;

endmodule
